// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational winner pick between CPU and DMA requests.
// Build option ARB_RR_EN selects round-robin; otherwise CPU priority with starvation override.
module mem_port_arbiter_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = 3
) (
  input  logic             i_cpu_req,
  input  logic             i_dma_req,
  input  owner_e           i_last_owner,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_valid,
  output owner_e           o_winner
);
  logic w_unused;

  assign o_valid = i_cpu_req | i_dma_req;

`ifdef ARB_RR_EN
  assign w_unused = ^i_starve_cnt;

  always_comb begin
    o_winner = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
      o_winner = (i_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (i_dma_req) begin
      o_winner = OWN_DMA;
    end
  end
`else
  assign w_unused = (i_last_owner == OWN_DMA);

  always_comb begin
    o_winner = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
      // DMA has lost STARVE_LIMIT contests in a row: let it through once.
      o_winner = (i_starve_cnt == CNT_W'(STARVE_LIMIT)) ? OWN_DMA : OWN_CPU;
    end else if (i_dma_req) begin
      o_winner = OWN_DMA;
    end
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto a single-port memory (IDLE -> ACCESS -> [RESP]).
// Build option: ARB_RR_EN = round-robin arbitration, starvation counter removed.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_cpu_gnt,
  output logic              o_dma_gnt,
  output logic              o_cpu_rvalid,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_adr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  owner_e            r_owner;
  owner_e            r_last_owner;
  owner_e            w_winner;
  logic              w_sel_valid;
  logic              w_select;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;
  logic [CNT_W-1:0]  w_starve_cnt;

  mem_port_arbiter_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb_select (
    .i_cpu_req    (i_cpu_req),
    .i_dma_req    (i_dma_req),
    .i_last_owner (r_last_owner),
    .i_starve_cnt (w_starve_cnt),
    .o_valid      (w_sel_valid),
    .o_winner     (w_winner)
  );

  assign w_select = (r_state == IDLE) && w_sel_valid;

`ifdef ARB_RR_EN
  assign w_starve_cnt = '0;
`else
  logic [CNT_W-1:0] r_starve_cnt;

  // Counts contests the DMA lost to the CPU; saturates at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_select) begin
      if (w_winner == OWN_DMA) begin
        r_starve_cnt <= '0;
      end else if (i_dma_req && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  assign w_starve_cnt = r_starve_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_cpu_gnt    = 1'b0;
    o_dma_gnt    = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_read   = ~r_we;
        o_mem_write  = r_we;
        o_cpu_gnt    = (r_owner == OWN_CPU);
        o_dma_gnt    = (r_owner == OWN_DMA);
        w_state_next = r_we ? IDLE : RESP;
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_we         <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      if (w_select) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        if (w_winner == OWN_CPU) begin
          r_we      <= i_cpu_we;
          r_mem_adr <= i_cpu_addr;
          if (i_cpu_we) begin
            r_mem_wdata <= i_cpu_wdata;
          end
        end else begin
          r_we      <= i_dma_we;
          r_mem_adr <= i_dma_addr;
          if (i_dma_we) begin
            r_mem_wdata <= i_dma_wdata;
          end
        end
      end
      // Memory answers the cycle after the read strobe; hand it to the owner only.
      if (r_state == RESP) begin
        if (r_owner == OWN_CPU) begin
          r_cpu_rdata  <= i_mem_rdata;
          r_cpu_rvalid <= 1'b1;
        end else begin
          r_dma_rdata  <= i_mem_rdata;
          r_dma_rvalid <= 1'b1;
        end
      end
    end
  end

  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_dma_rvalid = r_dma_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_dma_rdata  = r_dma_rdata;
  assign o_mem_adr    = r_mem_adr;
  assign o_mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model scheduling expected strobes per cycle.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIM = 4;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        cgnt;
    logic        dgnt;
    logic        rd;
    logic        wr;
    logic        cval;
    logic        dval;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write;
  logic [31:0] cpu_rdata, dma_rdata, mem_adr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int free_cyc = 0;
  int starve = 0;
  owner_e last_own = OWN_DMA;
  exp_t ev [8];
  logic [31:0] exp_crd = '0, exp_drd = '0;
  owner_e gq[$];
  txn_t cq[$], dq[$];
  bit cpu_gnt_prev = 1'b0, dma_gnt_prev = 1'b0;
  logic [31:0] tmem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_dma_req    (dma_req),
    .i_dma_we     (dma_we),
    .i_dma_addr   (dma_addr),
    .i_dma_wdata  (dma_wdata),
    .o_cpu_gnt    (cpu_gnt),
    .o_dma_gnt    (dma_gnt),
    .o_cpu_rvalid (cpu_rvalid),
    .o_dma_rvalid (dma_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .o_dma_rdata  (dma_rdata),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_mem_adr    (mem_adr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  // Memory device: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_write) tmem[mem_adr] = mem_wdata;
    if (mem_read) mem_rdata <= tmem.exists(mem_adr) ? tmem[mem_adr] : init_word(mem_adr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Arbitration decision for the current cycle, from the rules of the arbiter.
  task automatic model_select();
    owner_e w;
    bit c, d, we;
    logic [31:0] a, wd, rv;
    c = cpu_req;
    d = dma_req;
    if (!c && !d) begin
      free_cyc = cyc + 1;
      return;
    end
    if (c && d) begin
`ifdef ARB_RR_EN
      w = (last_own == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
      w = (starve == LIM) ? OWN_DMA : OWN_CPU;
`endif
    end else begin
      w = c ? OWN_CPU : OWN_DMA;
    end
`ifndef ARB_RR_EN
    if (w == OWN_DMA) starve = 0;
    else if (d && starve < LIM) starve++;
`endif
    last_own = w;
    gq.push_back(w);
    we = (w == OWN_CPU) ? cpu_we : dma_we;
    a  = (w == OWN_CPU) ? cpu_addr : dma_addr;
    wd = (w == OWN_CPU) ? cpu_wdata : dma_wdata;
    ev[(cyc+1)%8].cgnt  = (w == OWN_CPU);
    ev[(cyc+1)%8].dgnt  = (w == OWN_DMA);
    ev[(cyc+1)%8].rd    = !we;
    ev[(cyc+1)%8].wr    = we;
    ev[(cyc+1)%8].adr   = a;
    ev[(cyc+1)%8].wdata = wd;
    if (we) begin
      shadow[a] = wd;
      free_cyc = cyc + 2;
      $display("TXN cyc=%0d owner=%s WR addr=%h data=%h", cyc, (w == OWN_CPU) ? "CPU" : "DMA", a, wd);
    end else begin
      rv = shadow.exists(a) ? shadow[a] : init_word(a);
      ev[(cyc+3)%8].cval  = (w == OWN_CPU);
      ev[(cyc+3)%8].dval  = (w == OWN_DMA);
      ev[(cyc+3)%8].rdata = rv;
      free_cyc = cyc + 3;
      $display("TXN cyc=%0d owner=%s RD addr=%h data=%h", cyc, (w == OWN_CPU) ? "CPU" : "DMA", a, rv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int s;
    s = cyc % 8;
    if (rst) begin
      for (int i = 0; i < 8; i++) ev[i] = '0;
      exp_crd = '0; exp_drd = '0; starve = 0; last_own = OWN_DMA;
      free_cyc = cyc + 1;
      chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 0);
      chk("rst_dma_gnt", {31'd0, dma_gnt}, 0);
      chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
      chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 0);
      chk("rst_mem_rd_wr", {30'd0, mem_read, mem_write}, 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
    end else begin
      e = ev[s];
      ev[s] = '0;
      if (e.cval) exp_crd = e.rdata;
      if (e.dval) exp_drd = e.rdata;
      chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e.cgnt});
      chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, e.dgnt});
      chk("mem_read", {31'd0, mem_read}, {31'd0, e.rd});
      chk("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
      chk("strobe_excl", {31'd0, mem_read & mem_write}, 0);
      chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.cval});
      chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, e.dval});
      chk("cpu_rdata", cpu_rdata, exp_crd);
      chk("dma_rdata", dma_rdata, exp_drd);
      if (e.rd || e.wr) chk("mem_adr", mem_adr, e.adr);
      if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
      if (cyc == free_cyc) model_select();
    end
    cpu_gnt_prev = cpu_gnt;
    dma_gnt_prev = dma_gnt;
    cyc++;
  end

  function automatic txn_t mk(input bit we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Requesters hold each transaction until granted, then present the next one.
  task automatic step();
    @(posedge clk);
    #1;
    if (cpu_gnt_prev && cq.size() > 0) cq.delete(0);
    if (dma_gnt_prev && dq.size() > 0) dq.delete(0);
    cpu_req   = (cq.size() > 0);
    cpu_we    = cpu_req ? cq[0].we : 1'b0;
    cpu_addr  = cpu_req ? cq[0].addr : '0;
    cpu_wdata = cpu_req ? cq[0].wdata : '0;
    dma_req   = (dq.size() > 0);
    dma_we    = dma_req ? dq[0].we : 1'b0;
    dma_addr  = dma_req ? dq[0].addr : '0;
    dma_wdata = dma_req ? dq[0].wdata : '0;
  endtask

  initial begin
    owner_e pat [10];
    tmem[32'h10] = 32'hDEAD_BEEF;  shadow[32'h10] = 32'hDEAD_BEEF;
    tmem[32'h40] = 32'hCAFE_F00D;  shadow[32'h40] = 32'hCAFE_F00D;
    repeat (3) step();
    step();
    rst = 1'b0;

    // CPU read of 0x10
    cq.push_back(mk(1'b0, 32'h10, 32'h0));
    step();
    @(negedge clk) chk("t1_no_gnt_t", {31'd0, cpu_gnt}, 0);
    step();
    @(negedge clk);
    chk("t1_cpu_gnt", {31'd0, cpu_gnt}, 1);
    chk("t1_mem_read", {31'd0, mem_read}, 1);
    chk("t1_mem_adr", mem_adr, 32'h10);
    step();
    @(negedge clk) chk("t1_no_rvalid_t2", {31'd0, cpu_rvalid}, 0);
    step();
    @(negedge clk);
    chk("t1_cpu_rvalid", {31'd0, cpu_rvalid}, 1);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_dma_rvalid", {31'd0, dma_rvalid}, 0);
    chk("t1_dma_rdata", dma_rdata, 0);

    // DMA write 0x1234 to 0x20
    dq.push_back(mk(1'b1, 32'h20, 32'h1234));
    step();
    step();
    @(negedge clk);
    chk("t2_dma_gnt", {31'd0, dma_gnt}, 1);
    chk("t2_mem_write", {31'd0, mem_write}, 1);
    chk("t2_mem_adr", mem_adr, 32'h20);
    chk("t2_mem_wdata", mem_wdata, 32'h1234);
    chk("t2_cpu_gnt", {31'd0, cpu_gnt}, 0);
    step();
    @(negedge clk) chk("t2_no_rvalid", {31'd0, dma_rvalid}, 0);

    // Both requesters reading continuously
    gq.delete();
    for (int i = 0; i < 10; i++) begin
      cq.push_back(mk(1'b0, 32'h100 + i, 32'h0));
      dq.push_back(mk(1'b0, 32'h200 + i, 32'h0));
    end
    repeat (75) step();
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_RR_EN
      pat[i] = (i % 2 == 0) ? OWN_CPU : OWN_DMA;
`else
      pat[i] = (i % 5 == 4) ? OWN_DMA : OWN_CPU;
`endif
    end
    chk("t3_grant_count", gq.size(), 20);
    for (int i = 0; i < 10; i++) begin
      if (i < gq.size()) chk("t3_grant_order", {31'd0, gq[i]}, {31'd0, pat[i]});
    end
    chk("t3_drained", cq.size() + dq.size(), 0);

    // Reset asserted during RESP of a CPU read
    cq.push_back(mk(1'b0, 32'h30, 32'h0));
    step();
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("t4_abort_rvalid", {31'd0, cpu_rvalid}, 0);
    chk("t4_abort_rdata", cpu_rdata, 0);
    chk("t4_abort_adr", mem_adr, 0);
    step();
    @(negedge clk) chk("t4_no_rvalid_t3", {31'd0, cpu_rvalid}, 0);
    step();
    rst = 1'b0;
    dq.push_back(mk(1'b0, 32'h40, 32'h0));
    step();
    step();
    @(negedge clk) chk("t4_dma_gnt", {31'd0, dma_gnt}, 1);
    step();
    step();
    @(negedge clk);
    chk("t4_dma_rvalid", {31'd0, dma_rvalid}, 1);
    chk("t4_dma_rdata", dma_rdata, 32'hCAFE_F00D);
    chk("t4_cpu_rdata_clear", cpu_rdata, 0);

    // Mixed random traffic over a shared address window
    for (int i = 0; i < 16; i++) begin
      cq.push_back(mk(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 7)), $urandom));
      dq.push_back(mk(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 7)), $urandom));
    end
    for (int k = 0; k < 300 && (cq.size() + dq.size()) > 0; k++) step();
    repeat (5) step();
    chk("t5_drained", cq.size() + dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
